serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands over several clock cycles.
- Uses a single internal 4-bit ripple-carry adder slice built from full adders, processing one 4-bit nibble per cycle from LSB to MSB.
- Carry is registered between slices.
- Sits between a requester and the shared slice datapath, trading latency for area on wide additions.

Parameters:
- WIDTH, 16: operand and sum width. Must be a multiple of 4 and at least 8. NSLICE = WIDTH/4.

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled only in IDLE.
- a  input  WIDTH  operand A. Latched on accepted start.
- b  input  WIDTH  operand B. Latched on accepted start.
- c_in  input  1  carry-in to slice 0. Latched on accepted start.
- busy  output  1  high in RUN and DONE states.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result. Held until the next accepted start.
- c_out  output  1  carry out of the MSB slice.
- overflow  output  1  two's-complement signed overflow of the full WIDTH add.

Behaviour:
- One clock domain. Asynchronous active-low reset: resetn low immediately forces the following.
  - State = IDLE.
  - busy = 0, done = 0, sum = 0, c_out = 0, overflow = 0.
  - Slice counter = 0, carry register = 0, operand registers = 0.
- States:
  - IDLE: busy = 0. If start = 1 at a rising edge: latch a, b and c_in; counter = 0; carry register = c_in; go to RUN. Otherwise stay in IDLE.
  - RUN: busy = 1. Each cycle, the slice adds nibble[counter] of A, nibble[counter] of B and the carry register.
    - At the edge, the 4-bit slice result is written into sum nibble[counter] and the slice carry-out into the carry register.
    - The counter increments.
    - When counter = NSLICE-1 at the edge, go to DONE.
  - DONE: busy = 1, done = 1 for exactly one cycle.
    - c_out = final carry register.
    - overflow = (carry into MSB) XOR c_out. Carry into MSB = a[W-1] ^ b[W-1] ^ sum[W-1], using the latched operands.
    - Next state is IDLE unconditionally.
- Latency: start sampled at edge t → done high in the cycle after edge t+NSLICE, i.e. NSLICE+1 cycles after acceptance. Throughput is one add per NSLICE+2 cycles at most.
- start in RUN or DONE is ignored. Inputs a, b and c_in may change freely after acceptance; there is no effect on the result in flight.
- sum nibbles update progressively during RUN, so sum is only valid while done = 1 and afterwards in IDLE.
- c_out and overflow are updated only on entry to DONE and held in IDLE.
- Reset mid-RUN aborts the operation with no done pulse. All outputs are cleared as above.
- Wrap-around: sum is modulo 2^WIDTH. The carry beyond the MSB appears only on c_out.
- start held high continuously: a new operation is accepted in each IDLE cycle, giving back-to-back operations separated by one IDLE cycle.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched with the operands on accepted start.
  - If the latched sub = 1: B is inverted before the slice and the initial carry register is forced to 1 (c_in ignored), so sum = A - B.
  - c_out = 1 means no borrow. overflow is computed on the inverted B.
  - sub = 0 behaves identically to the undefined case.
- Undefined: no sub port; addition only.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0FED, c_in=0, start pulse → busy for 5 cycles, done pulse in cycle 5, sum=0x2221, c_out=0, overflow=0.
- a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1, overflow=0. Then a=0x7FFF, b=0x0000, c_in=1 → sum=0x8000, c_out=0, overflow=1.
- start held high with a=0x0001, b=0x0001; change a to 0x00FF during RUN → first result 0x0002. The new request is accepted only in the IDLE cycle after done, then yields 0x0100.
- Assert resetn=0 during the second RUN cycle of 0xAAAA+0x5555 → all outputs 0 immediately, no done pulse. After release, a fresh start with 0x0003+0x0004 → sum=0x0007.
- WIDTH=8, a=0xF0, b=0x10, c_in=0 → done after 3 cycles, sum=0x00, c_out=1, overflow=0.
- SERIAL_ADDER_SUB_EN defined, sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, c_out=0, overflow=0. With sub=1, a=0x8000, b=0x0001 → sum=0x7FFF, c_out=1, overflow=1.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: adds two WIDTH-bit operands over several cycles. One
// 4-bit ripple-carry slice handles a nibble per cycle, LSB first, and the
// carry is registered between nibbles.
// Optional feature: define SERIAL_ADDER_SUB_EN to add a 'sub' input. When
// sub is set, B is inverted and the initial carry is forced to 1, so the
// result is A - B.

// Single full adder. Four of these are chained to form the nibble slice.
module serial_adder_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 16  // multiple of 4, >= 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);
  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;  // b_q holds B already inverted for subtract
  logic [CW-1:0]    cnt;
  logic             carry;

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [3:0]       nib_a, nib_b, nib_s;
  logic             slice_co;

  // Operand conditioning applied once, at acceptance.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : c_in;
`else
  assign b_eff = b;
  assign c_eff = c_in;
`endif

  assign nib_a = a_q[cnt*4 +: 4];
  assign nib_b = b_q[cnt*4 +: 4];

  // Nibble slice: carry threaded through per-bit generate blocks so each
  // stage's carry is its own net.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    logic ci, co;
    if (i == 0) begin : g_c0
      assign ci = carry;
    end else begin : g_cn
      assign ci = g_fa[i-1].co;
    end
    serial_adder_fa u_fa (
      .x  (nib_a[i]),
      .y  (nib_b[i]),
      .ci (ci),
      .s  (nib_s[i]),
      .co (co)
    );
  end
  assign slice_co = g_fa[3].co;

  // Sequencer: accept in IDLE, one nibble per RUN cycle, one-cycle DONE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      cnt      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b_eff;
            carry <= c_eff;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum[cnt*4 +: 4] <= nib_s;
          carry           <= slice_co;
          cnt             <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Final slice: MSB carry-in recovered as a^b^s at bit WIDTH-1.
            state    <= DONE;
            done     <= 1'b1;
            c_out    <= slice_co;
            overflow <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ nib_s[3] ^ slice_co;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: a vector table plus hand sequences for
// back-to-back start, reset abort and an 8-bit instance; results are
// checked by a scoreboard on each done pulse.
module tb_serial_adder_ctrl;
  localparam int W  = 16;
  localparam int NS = W / 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0, b = '0;
  logic          c_in = 1'b0;
  logic          sub_s = 1'b0;
  logic          busy, done, c_out, overflow;
  logic [W-1:0]  sum;

  logic          start8 = 1'b0;
  logic [7:0]    a8 = '0, b8 = '0;
  logic          c_in8 = 1'b0;
  logic          busy8, done8, c_out8, ovf8;
  logic [7:0]    sum8;

  always #5 clock = ~clock;

  serial_adder_ctrl #(.WIDTH(W)) u_dut (
    .clock(clock), .resetn(resetn), .start(start), .a(a), .b(b), .c_in(c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_s),
`endif
    .busy(busy), .done(done), .sum(sum), .c_out(c_out), .overflow(overflow)
  );

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clock(clock), .resetn(resetn), .start(start8), .a(a8), .b(b8), .c_in(c_in8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .c_out(c_out8), .overflow(ovf8)
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] sum;
    logic         cout, ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout, ovf;
  } exp_t;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clock) begin : mon
    exp_t e;
    if (resetn && done) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("sum", {16'd0, sum}, {16'd0, e.sum});
        chk("c_out", {31'd0, c_out}, {31'd0, e.cout});
        chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
      end
    end
  end

  // Counts negedges (current one = 1) until done, noting any non-busy cycle.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = k;
        return;
      end
      @(negedge clock);
    end
  endtask

  task automatic do_op(input vec_t v);
    int lat;
    bit bok;
    @(negedge clock);
    a = v.a; b = v.b; c_in = v.cin; sub_s = v.sub; start = 1'b1;
    @(posedge clock);
    sb.push_back('{sum: v.sum, cout: v.cout, ovf: v.ovf});
    @(negedge clock);
    start = 1'b0; a = ~v.a; b = ~v.b; c_in = ~v.cin;  // must not disturb result
    wait_done(lat, bok);
    chk("latency", lat, NS + 1);
    chk("busy_run", {31'd0, bok}, 32'd1);
    @(negedge clock);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("sum_hold", {16'd0, sum}, {16'd0, v.sum});
  endtask

  initial begin
    int lat;
    bit bok;
    tbl.push_back('{16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0});
    tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    tbl.push_back('{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1});
    tbl.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
    tbl.push_back('{16'h1234, 16'h5678, 1'b1, 1'b0, 16'h68AD, 1'b0, 1'b0});
    tbl.push_back('{16'h7000, 16'h1000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    tbl.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    tbl.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
    tbl.push_back('{16'h0009, 16'h0003, 1'b0, 1'b1, 16'h0006, 1'b1, 1'b0});
`endif

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, c_out}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    resetn = 1'b1;

    foreach (tbl[i]) do_op(tbl[i]);

    // start held high: second request accepted only in the IDLE cycle after done
    @(negedge clock);
    a = 16'h0001; b = 16'h0001; c_in = 1'b0; sub_s = 1'b0; start = 1'b1;
    @(posedge clock);
    sb.push_back('{sum: 16'h0002, cout: 1'b0, ovf: 1'b0});
    @(negedge clock);
    a = 16'h00FF;
    wait_done(lat, bok);
    chk("held_lat1", lat, NS + 1);
    @(negedge clock);
    chk("held_idle_gap", {31'd0, busy}, 32'd0);
    sb.push_back('{sum: 16'h0100, cout: 1'b0, ovf: 1'b0});
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    chk("held_reaccept", {31'd0, busy}, 32'd1);
    wait_done(lat, bok);
    chk("held_lat2", lat, NS + 1);
    @(negedge clock);

    // Reset during the second RUN cycle aborts with no done pulse
    @(negedge clock);
    a = 16'hAAAA; b = 16'h5555; c_in = 1'b0; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sum", {16'd0, sum}, 32'd0);
    chk("abort_cout", {31'd0, c_out}, 32'd0);
    chk("abort_ovf", {31'd0, overflow}, 32'd0);
    repeat (3) begin
      @(negedge clock);
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    resetn = 1'b1;
    do_op('{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0});

    // 8-bit instance: two slices
    @(negedge clock);
    a8 = 8'hF0; b8 = 8'h10; c_in8 = 1'b0; start8 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start8 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (done8) begin
        lat = k;
        break;
      end
      @(negedge clock);
    end
    chk("w8_latency", lat, 3);
    chk("w8_sum", {24'd0, sum8}, 32'h00);
    chk("w8_cout", {31'd0, c_out8}, 32'd1);
    chk("w8_ovf", {31'd0, ovf8}, 32'd0);

    repeat (2) @(negedge clock);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
